// File: rtl/gbc_mem_pkg.sv
// Shared memory-subsystem types: bus widths, requester ownership and read-return tags.
package gbc_mem_pkg;

  localparam int unsigned GBC_ADDR_W = 16;
  localparam int unsigned GBC_DATA_W = 8;
  localparam int unsigned WAIT_W     = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// CPU, DMA and BRAM-pin bundle around the arbiter; master is the surrounding system.
interface bram_arbiter_if #(
  parameter int unsigned ADDR_W = gbc_mem_pkg::GBC_ADDR_W,
  parameter int unsigned DATA_W = gbc_mem_pkg::GBC_DATA_W
) ();

  logic [ADDR_W-1:0] I_CPU_ADDR;
  logic [DATA_W-1:0] I_CPU_WDATA;
  logic              I_CPU_WE_L;
  logic              I_CPU_RE_L;
  logic              O_CPU_ACK;
  logic [DATA_W-1:0] O_CPU_RDATA;
  logic              O_CPU_RVALID;

  logic              I_DMA_REQ;
  logic              I_DMA_WE;
  logic [ADDR_W-1:0] I_DMA_ADDR;
  logic [DATA_W-1:0] I_DMA_WDATA;
  logic              O_DMA_GNT;
  logic [DATA_W-1:0] O_DMA_RDATA;
  logic              O_DMA_RVALID;

  logic              O_BRAM_EN;
  logic              O_BRAM_WE;
  logic [ADDR_W-1:0] O_BRAM_ADDR;
  logic [DATA_W-1:0] O_BRAM_DIN;
  logic [DATA_W-1:0] I_BRAM_DOUT;

  modport master (
    output I_CPU_ADDR, I_CPU_WDATA, I_CPU_WE_L, I_CPU_RE_L,
    input  O_CPU_ACK, O_CPU_RDATA, O_CPU_RVALID,
    output I_DMA_REQ, I_DMA_WE, I_DMA_ADDR, I_DMA_WDATA,
    input  O_DMA_GNT, O_DMA_RDATA, O_DMA_RVALID,
    input  O_BRAM_EN, O_BRAM_WE, O_BRAM_ADDR, O_BRAM_DIN,
    output I_BRAM_DOUT
  );

  modport slave (
    input  I_CPU_ADDR, I_CPU_WDATA, I_CPU_WE_L, I_CPU_RE_L,
    output O_CPU_ACK, O_CPU_RDATA, O_CPU_RVALID,
    input  I_DMA_REQ, I_DMA_WE, I_DMA_ADDR, I_DMA_WDATA,
    output O_DMA_GNT, O_DMA_RDATA, O_DMA_RVALID,
    output O_BRAM_EN, O_BRAM_WE, O_BRAM_ADDR, O_BRAM_DIN,
    input  I_BRAM_DOUT
  );

endinterface

// File: rtl/bram_rd_return.sv
// Two-stage read tag pipeline: routes BRAM read data back to the requester that issued it.
module bram_rd_return
  import gbc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = GBC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_issue_i,
  input  owner_e            rd_owner_i,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o
);

  rd_tag_t           tag0_q, tag0_d;
  rd_tag_t           tag1_q, tag1_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic              cpu_hit, dma_hit;

  // Stage 0 is the issue edge, stage 1 the BRAM sample edge; data is captured one edge later.
  always_comb begin
    tag0_d.valid = rd_issue_i;
    tag0_d.owner = rd_issue_i ? rd_owner_i : OWN_NONE;
    tag1_d       = tag0_q;
    cpu_hit      = tag1_q.valid && (tag1_q.owner == OWN_CPU);
    dma_hit      = tag1_q.valid && (tag1_q.owner == OWN_DMA);
    cpu_rvalid_d = cpu_hit;
    dma_rvalid_d = dma_hit;
    cpu_rdata_d  = cpu_hit ? bram_dout_i : cpu_rdata_q;
    dma_rdata_d  = dma_hit ? bram_dout_i : dma_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag0_q       <= '0;
      tag1_q       <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dma_rdata_o  = dma_rdata_q;
  assign dma_rvalid_o = dma_rvalid_q;

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter: CPU priority, one-cycle re-grant mask and a DMA starvation guard.
module bram_arbiter
  import gbc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = GBC_ADDR_W,
  parameter int unsigned DATA_W       = GBC_DATA_W,
  parameter int unsigned MAX_DMA_WAIT = 4
) (
  input logic           I_CLK,
  input logic           I_RESET_L,
  bram_arbiter_if.slave bus
);

  owner_e            last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ack_q, ack_d;
  logic              gnt_q, gnt_d;

  logic   cpu_req, cpu_wr, dma_req;
  logic   cpu_elig, dma_elig, dma_forced;
  logic   rd_issue;
  owner_e win;

  // Winner selection; last cycle's grantee sits out one cycle so it can drop its request.
  always_comb begin
    cpu_wr     = ~bus.I_CPU_WE_L;
    cpu_req    = cpu_wr | ~bus.I_CPU_RE_L;
    dma_req    = bus.I_DMA_REQ;
    cpu_elig   = cpu_req && (last_q != OWN_CPU);
    dma_elig   = dma_req && (last_q != OWN_DMA);
    dma_forced = dma_elig && (wait_q == WAIT_W'(MAX_DMA_WAIT));
    win        = OWN_NONE;
    if (dma_forced) begin
      win = OWN_DMA;
    end else if (cpu_elig) begin
      win = OWN_CPU;
    end else if (dma_elig) begin
      win = OWN_DMA;
    end
  end

  always_comb begin
    en_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    ack_d  = 1'b0;
    gnt_d  = 1'b0;
    last_d = win;
    wait_d = wait_q;
    case (win)
      OWN_CPU: begin
        en_d   = 1'b1;
        we_d   = cpu_wr;
        addr_d = bus.I_CPU_ADDR;
        if (cpu_wr) din_d = bus.I_CPU_WDATA;
        ack_d  = 1'b1;
      end
      OWN_DMA: begin
        en_d   = 1'b1;
        we_d   = bus.I_DMA_WE;
        addr_d = bus.I_DMA_ADDR;
        if (bus.I_DMA_WE) din_d = bus.I_DMA_WDATA;
        gnt_d  = 1'b1;
      end
      default: ;
    endcase
    // A masked DMA neither ages nor clears; it just waits out its mask cycle.
    if (!dma_req || (win == OWN_DMA)) begin
      wait_d = '0;
    end else if ((last_q != OWN_DMA) && (wait_q < WAIT_W'(MAX_DMA_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    rd_issue = en_d & ~we_d;
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_L) begin
      last_q <= OWN_NONE;
      wait_q <= '0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      ack_q  <= 1'b0;
      gnt_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      wait_q <= wait_d;
      en_q   <= en_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      ack_q  <= ack_d;
      gnt_q  <= gnt_d;
    end
  end

  assign bus.O_BRAM_EN   = en_q;
  assign bus.O_BRAM_WE   = we_q;
  assign bus.O_BRAM_ADDR = addr_q;
  assign bus.O_BRAM_DIN  = din_q;
  assign bus.O_CPU_ACK   = ack_q;
  assign bus.O_DMA_GNT   = gnt_q;

  bram_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clk_i        (I_CLK),
    .rst_ni       (I_RESET_L),
    .rd_issue_i   (rd_issue),
    .rd_owner_i   (win),
    .bram_dout_i  (bus.I_BRAM_DOUT),
    .cpu_rdata_o  (bus.O_CPU_RDATA),
    .cpu_rvalid_o (bus.O_CPU_RVALID),
    .dma_rdata_o  (bus.O_DMA_RDATA),
    .dma_rvalid_o (bus.O_DMA_RVALID)
  );

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port, synchronous-read block RAM (16-bit address, 8-bit data, 1-cycle read latency) between two requesters: the CPU memory port and the DMA engine (OAM/HDMA copies).
- Issues at most one BRAM access per cycle, with fixed CPU priority and a bounded-wait starvation guard for DMA.
- Returns read data to the requester that issued the read.
- Sits between the memory router and the BRAM primitive, and drives the BRAM enable, write-enable, address and data-in pins directly.

Parameters:
- ADDR_W, 16, address width of both requesters and the BRAM.
- DATA_W, 8, data width.
- MAX_DMA_WAIT, 4, number of consecutive cycles a pending DMA request may lose to the CPU before DMA is forced to win. Legal range 1..15.

Ports:
- I_CLK  in  1  system clock; all logic is on its rising edge.
- I_RESET_L  in  1  synchronous, active-low reset.
- I_CPU_ADDR  in  ADDR_W  CPU address.
- I_CPU_WDATA  in  DATA_W  CPU write data.
- I_CPU_WE_L  in  1  CPU write request, active low.
- I_CPU_RE_L  in  1  CPU read request, active low.
- O_CPU_ACK  out  1  one-cycle pulse: the CPU access was issued.
- O_CPU_RDATA  out  DATA_W  CPU read data.
- O_CPU_RVALID  out  1  one-cycle pulse: O_CPU_RDATA is valid.
- I_DMA_REQ  in  1  DMA request, active high.
- I_DMA_WE  in  1  1 = write, 0 = read; qualified by I_DMA_REQ.
- I_DMA_ADDR  in  ADDR_W  DMA address.
- I_DMA_WDATA  in  DATA_W  DMA write data.
- O_DMA_GNT  out  1  one-cycle pulse: the DMA access was issued.
- O_DMA_RDATA  out  DATA_W  DMA read data.
- O_DMA_RVALID  out  1  one-cycle pulse: O_DMA_RDATA is valid.
- O_BRAM_EN  out  1  BRAM enable.
- O_BRAM_WE  out  1  BRAM write enable.
- O_BRAM_ADDR  out  ADDR_W  BRAM address.
- O_BRAM_DIN  out  DATA_W  BRAM write data.
- I_BRAM_DOUT  in  DATA_W  BRAM read data.

Behaviour:
- Clocking and reset: one clock, I_CLK. Reset is synchronous and active low on I_RESET_L.
- Reset values: all outputs 0 (EN, WE, ADDR, DIN, ACK, GNT, RDATA, RVALID). Wait counter 0. Grant mask NONE. Read-tag pipeline cleared.
- Reset mid-operation: reads already in flight are dropped and produce no RVALID. No BRAM access is issued while I_RESET_L is low.
- Request definition:
  - cpu_req = ~I_CPU_WE_L | ~I_CPU_RE_L. If both are low, the access is a write.
  - dma_req = I_DMA_REQ.
  - Requests are levels. A requester holds address, data and request stable until it sees ACK/GNT.
- Arbitration runs every cycle on the registered state. Grant mask last ∈ {NONE, CPU, DMA} holds the requester granted in the previous cycle; that requester is ineligible this cycle. This gives it one cycle to drop its request after seeing the pulse. Each requester therefore gets at most one grant every 2 cycles, while the BRAM can still be 100% busy with alternating grants.
- Winner selection:
  1. If eligible dma_req and wait_cnt == MAX_DMA_WAIT: DMA wins.
  2. Else if eligible cpu_req: CPU wins.
  3. Else if eligible dma_req: DMA wins.
  4. Else: no access.
- wait_cnt update:
  - Cleared on a DMA grant or when dma_req is low.
  - Incremented, saturating at MAX_DMA_WAIT, when dma_req is high and DMA loses.
  - A masked DMA (last == DMA) does not increment.
- Issue timing: at the edge where the decision is made, register O_BRAM_EN=1, O_BRAM_WE, O_BRAM_ADDR and O_BRAM_DIN (write only; otherwise hold the previous value). In the same edge, pulse the winner's ACK/GNT for exactly one cycle. With no winner, O_BRAM_EN=0 and O_BRAM_WE=0.
- Read return:
  - A 2-stage tag pipeline {valid, owner} tracks reads.
  - BRAM samples at edge E+1 and its data is valid after E+1.
  - The arbiter captures I_BRAM_DOUT at edge E+2 into the owner's RDATA and pulses the owner's RVALID for one cycle.
  - Read latency is ACK/GNT pulse to RVALID pulse = 2 cycles.
  - Back-to-back reads return in issue order, one per cycle.
  - The RDATA of the non-owner holds its value.
- Writes produce no RVALID. A read issued the cycle after a write to the same address returns the new data (BRAM write-first mode).
- Simultaneous requests with last == CPU: DMA wins that cycle (masking), with no starvation logic needed.

Decomposition:
- Shared package gbc_mem_pkg:
  - owner enum: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2.
  - Constants GBC_ADDR_W=16, GBC_DATA_W=8.
- Natural sub-module: bram_rd_return, the 2-stage tag pipeline plus RDATA/RVALID demux. The arbiter core and issue registers stay in bram_arbiter.

Test Plan:
- Reset: hold I_RESET_L=0 with cpu_req active → O_BRAM_EN=0 and all ACK/GNT/RVALID 0; release reset → first ACK one cycle later.
- CPU write then read: CPU write 0x5A to 0xC010, then CPU read 0xC010 → O_BRAM_WE=1 with ADDR=0xC010 and DIN=0x5A; O_CPU_RVALID 2 cycles after the read ACK with O_CPU_RDATA=0x5A; O_DMA_RVALID stays 0.
- Simultaneous reads: CPU reads 0xC000 and DMA reads 0xFE00, both held → order CPU, DMA, CPU, DMA…; BRAM EN high every cycle; each RVALID goes only to its owner with the correct data.
- Starvation guard: CPU and DMA requests held continuously, with the CPU re-requesting immediately after each ACK → DMA is granted no later than MAX_DMA_WAIT+1 cycles after its request; wait_cnt returns to 0 after GNT.
- Reset mid-operation: assert I_RESET_L=0 on the cycle after a DMA read GNT → no O_DMA_RVALID is ever produced; state returns to the reset values.
- Both enables low: I_CPU_WE_L=0 and I_CPU_RE_L=0 → a write is issued, ACK pulses once, and no RVALID follows.
